instruction_cache: RTL and testbench



---
 rtl/icache_pkg.sv | 16 +
 rtl/instruction_cache_if.sv | 22 ++
 rtl/icache_block_store.sv | 42 ++++
 rtl/instruction_cache.sv | 100 ++++++++++
 tb/tb_instruction_cache.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/icache_pkg.sv
// Shared types and field widths for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEM_READ,
    UPDATE
  } icache_state_e;

  localparam int OFFSET_BITS      = 2;   // word offset inside a block
  localparam int BLOCK_BYTES      = 16;
  localparam int BLOCK_BITS       = 128;
  localparam int WORD_BITS        = 32;
  localparam int BYTE_OFFSET_BITS = $clog2(BLOCK_BYTES);

endpackage

// File: rtl/instruction_cache_if.sv
// CPU fetch port plus block-wide instruction memory port of the instruction cache.
interface instruction_cache_if #(
  parameter int ADDR_BITS = 10
);
  logic [31:0]          PC;
  logic [31:0]          INSTRUCTION;
  logic                 BUSYWAIT;
  logic                 MEM_READ;
  logic [ADDR_BITS-5:0] MEM_ADDRESS;
  logic [127:0]         MEM_READDATA;
  logic                 MEM_BUSYWAIT;

  modport slave (
    input  PC, MEM_READDATA, MEM_BUSYWAIT,
    output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
  );

  modport master (
    output PC, MEM_READDATA, MEM_BUSYWAIT,
    input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
  );
endinterface

// File: rtl/icache_block_store.sv
// Valid/tag/data arrays of the cache: one synchronous write port, one
// asynchronous read port, valid bits cleared asynchronously on reset.
module icache_block_store
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [BLOCK_BITS-1:0] wr_block,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [BLOCK_BITS-1:0] rd_block
);
  localparam int NUM_BLOCKS = 1 << INDEX_BITS;

  logic [NUM_BLOCKS-1:0] valid_q;
  logic [TAG_BITS-1:0]   tag_q  [NUM_BLOCKS];
  logic [BLOCK_BITS-1:0] data_q [NUM_BLOCKS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     valid_q         <= '0;
    else if (we) valid_q[wr_idx] <= 1'b1;
  end

  // Tag and data need no reset: they are never looked at while valid is 0.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_block;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_block = data_q[rd_idx];
endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: combinational hit path and a
// three-state block fill controller (IDLE -> MEM_READ -> UPDATE).
module instruction_cache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 3,
  parameter int ADDR_BITS  = 10
) (
  input  logic                CLK,
  input  logic                RESET,
  instruction_cache_if.slave  bus
);
  localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - BYTE_OFFSET_BITS;

  logic [TAG_BITS-1:0]    pc_tag, lat_tag, rd_tag;
  logic [INDEX_BITS-1:0]  pc_idx, lat_idx;
  logic [OFFSET_BITS-1:0] pc_off;
  logic [BLOCK_BITS-1:0]  rd_block, fill_q;
  logic                   rd_valid, hit, busy, mem_read, miss_start, fill_done;
  icache_state_e          state_q, state_d;
  logic                   unused_pc;

  assign pc_off    = bus.PC[BYTE_OFFSET_BITS-1:2];
  assign pc_idx    = bus.PC[INDEX_BITS+BYTE_OFFSET_BITS-1:BYTE_OFFSET_BITS];
  assign pc_tag    = bus.PC[ADDR_BITS-1:INDEX_BITS+BYTE_OFFSET_BITS];
  assign unused_pc = ^{bus.PC[31:ADDR_BITS], bus.PC[1:0]};

  icache_block_store #(
    .INDEX_BITS(INDEX_BITS),
    .TAG_BITS  (TAG_BITS)
  ) u_store (
    .clk     (CLK),
    .rst     (RESET),
    .we      (state_q == UPDATE),
    .wr_idx  (lat_idx),
    .wr_tag  (lat_tag),
    .wr_block(fill_q),
    .rd_idx  (pc_idx),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_block(rd_block)
  );

  assign hit = rd_valid && (rd_tag == pc_tag);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    busy       = 1'b0;
    mem_read   = 1'b0;
    miss_start = 1'b0;
    fill_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!hit) begin
          busy       = 1'b1;
          miss_start = 1'b1;
          state_d    = MEM_READ;
        end
      end
      MEM_READ: begin
        busy     = 1'b1;
        mem_read = 1'b1;
        if (!bus.MEM_BUSYWAIT) begin
          fill_done = 1'b1;
          state_d   = UPDATE;
        end
      end
      UPDATE: begin
        busy    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The fill works from the latched block address, so PC may wander mid-fill.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lat_tag <= '0;
      lat_idx <= '0;
    end else if (miss_start) begin
      lat_tag <= pc_tag;
      lat_idx <= pc_idx;
    end
  end

  always_ff @(posedge CLK) begin
    if (fill_done) fill_q <= bus.MEM_READDATA;
  end

  assign bus.MEM_READ    = mem_read;
  assign bus.MEM_ADDRESS = {lat_tag, lat_idx};
  assign bus.BUSYWAIT    = busy && !RESET;
  assign bus.INSTRUCTION = (busy || RESET) ? 32'h0 : rd_block[{pc_off, 5'b0} +: WORD_BITS];
endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache: a block-level behavioural model checked
// every cycle, plus hand-computed expectations for the miss/hit scenarios.
module tb_instruction_cache;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   mem_lat = 5;

  instruction_cache_if #(.ADDR_BITS(10)) bus();

  instruction_cache #(
    .INDEX_BITS(3),
    .ADDR_BITS (10)
  ) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Memory image: block 0 is {44,33,22,11}; block b word w is A000_0000|b<<8|w.
  function automatic logic [31:0] word_of(input int blk, input int w);
    if (blk == 0) return 32'(32'h11 * (w + 1));
    return 32'(32'hA000_0000 | (blk << 8) | w);
  endfunction

  function automatic logic [127:0] block_of(input int blk);
    logic [127:0] b;
    for (int w = 0; w < 4; w++) b[w*32 +: 32] = word_of(blk, w);
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Slow memory: MEM_BUSYWAIT high for mem_lat cycles of a request, then data.
  int mcnt = 0;
  always @(negedge clk) begin
    if (bus.MEM_READ) begin
      if (mcnt < mem_lat) begin
        bus.MEM_BUSYWAIT = 1'b1;
        mcnt++;
      end else begin
        bus.MEM_BUSYWAIT = 1'b0;
        bus.MEM_READDATA = block_of(int'(bus.MEM_ADDRESS));
      end
    end else begin
      mcnt = 0;
      bus.MEM_BUSYWAIT = 1'b0;
    end
  end

  // Model: which block lives at each index, and how far into a fill we are.
  logic       m_valid [8];
  logic [2:0] m_tag   [8];
  logic [5:0] m_addr  = '0;
  logic [2:0] m_idx, m_tg;
  int         k = 0;
  int         lat_m = 0;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
      k = 0;
      chk("rst_busy",  32'(bus.BUSYWAIT), 0);
      chk("rst_mread", 32'(bus.MEM_READ), 0);
      chk("rst_instr", bus.INSTRUCTION, 0);
    end else if (k == 0) begin
      m_idx = bus.PC[6:4];
      m_tg  = bus.PC[9:7];
      if (m_valid[m_idx] && m_tg == m_tag[m_idx]) begin
        chk("hit_busy",  32'(bus.BUSYWAIT), 0);
        chk("hit_mread", 32'(bus.MEM_READ), 0);
        chk("hit_instr", bus.INSTRUCTION, word_of(int'({m_tg, m_idx}), int'(bus.PC[3:2])));
      end else begin
        // The IDLE miss cycle has just passed; the first MEM_READ cycle is showing.
        m_addr = {m_tg, m_idx};
        lat_m  = mem_lat;
        k      = 1;
        chk("miss_busy",  32'(bus.BUSYWAIT), 1);
        chk("miss_mread", 32'(bus.MEM_READ), 1);
        chk("miss_instr", bus.INSTRUCTION, 0);
        chk("miss_addr",  32'(bus.MEM_ADDRESS), 32'(m_addr));
      end
    end else if (k <= lat_m) begin
      k++;
      chk("rd_busy",  32'(bus.BUSYWAIT), 1);
      chk("rd_mread", 32'(bus.MEM_READ), 1);
      chk("rd_addr",  32'(bus.MEM_ADDRESS), 32'(m_addr));
    end else begin
      chk("upd_busy",  32'(bus.BUSYWAIT), 1);
      chk("upd_mread", 32'(bus.MEM_READ), 0);
      chk("upd_instr", bus.INSTRUCTION, 0);
      m_valid[m_addr[2:0]] = 1'b1;
      m_tag[m_addr[2:0]]   = m_addr[5:3];
      k = 0;
    end
  end

  // Apply PC now; count stalled samples until the word appears.
  task automatic run_access(input logic [31:0] pc, output int nbusy, output int nmr,
                            output logic [31:0] instr, output logic [31:0] addr);
    bus.PC = pc;
    nbusy = 0;
    nmr   = 0;
    instr = '0;
    addr  = '0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      if (!bus.BUSYWAIT) begin
        instr = bus.INSTRUCTION;
        return;
      end
      nbusy++;
      if (bus.MEM_READ) begin
        if (nmr == 0) addr = 32'(bus.MEM_ADDRESS);
        nmr++;
      end
    end
    total++;
    bad++;
    $display("FAIL timeout pc=%h: got busy=%0d cycles want done within 60", pc, nbusy);
  endtask

  // Stalled samples = L+2 (L+1 in MEM_READ, 1 in UPDATE) after the miss cycle.
  task automatic access(input logic [31:0] pc, input int exp_busy, input int exp_mr,
                        input logic [31:0] exp_instr, input logic [31:0] exp_addr,
                        input string name);
    int nb, nm;
    logic [31:0] ins, ad;
    @(negedge clk);
    run_access(pc, nb, nm, ins, ad);
    chk({name, "_busycyc"}, 32'(nb), 32'(exp_busy));
    chk({name, "_mrcyc"},   32'(nm), 32'(exp_mr));
    chk({name, "_instr"},   ins, exp_instr);
    if (exp_mr > 0) chk({name, "_maddr"}, ad, exp_addr);
  endtask

  initial begin
    rst              = 1'b1;
    bus.PC           = '0;
    bus.MEM_READDATA = '0;
    bus.MEM_BUSYWAIT = 1'b0;
    @(posedge clk);
    #2;
    chk("reset_busy",  32'(bus.BUSYWAIT), 0);
    chk("reset_mread", 32'(bus.MEM_READ), 0);
    chk("reset_maddr", 32'(bus.MEM_ADDRESS), 0);
    chk("reset_instr", bus.INSTRUCTION, 0);
    @(posedge clk);
    #2 rst = 1'b0;

    mem_lat = 5;
    access(32'h000, 7, 6, 32'h11, 32'h00, "first_miss");
    access(32'h004, 0, 0, 32'h22, 32'h00, "hit_w1");
    access(32'h008, 0, 0, 32'h33, 32'h00, "hit_w2");
    access(32'h00C, 0, 0, 32'h44, 32'h00, "hit_w3");
    access(32'h080, 7, 6, 32'hA000_0800, 32'h08, "conflict");
    access(32'h000, 7, 6, 32'h11, 32'h00, "evicted");

    mem_lat = 2;
    access(32'h010, 4, 3, 32'hA000_0100, 32'h01, "idx1_miss");
    access(32'h020, 4, 3, 32'hA000_0200, 32'h02, "idx2_miss");
    access(32'h014, 0, 0, 32'hA000_0101, 32'h00, "idx1_hit");
    access(32'h02C, 0, 0, 32'hA000_0203, 32'h00, "idx2_hit");

    mem_lat = 1;
    access(32'h3FC, 3, 2, 32'hA000_3F03, 32'h3F, "top_block");

    // Reset in the middle of a fill at index 3.
    mem_lat = 5;
    @(negedge clk);
    bus.PC = 32'h030;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("abort_pre_mread", 32'(bus.MEM_READ), 1);
    rst = 1'b1;
    #1;
    chk("abort_mread", 32'(bus.MEM_READ), 0);
    chk("abort_busy",  32'(bus.BUSYWAIT), 0);
    chk("abort_instr", bus.INSTRUCTION, 0);
    chk("abort_maddr", 32'(bus.MEM_ADDRESS), 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    access(32'h000, 7, 6, 32'h11, 32'h00, "post_rst_pc0");
    access(32'h030, 7, 6, 32'hA000_0300, 32'h03, "aborted_idx");

    mem_lat = 0;
    access(32'h044, 2, 1, 32'hA000_0401, 32'h04, "zero_lat");
    access(32'h048, 0, 0, 32'hA000_0402, 32'h00, "zero_lat_hit");

    repeat (3) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
